// File: rtl/rom_prefetch.sv
// ============================================================================
// rom_prefetch : J1 instruction prefetch FIFO between code ROM and core fetch
// Revision     : 1.0
// ============================================================================
`default_nettype none

module rom_prefetch #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_cen,
  input  logic [DATA_WIDTH-1:0] rom_q,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  insn_valid,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  input  logic                  insn_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
  localparam logic [CNT_W:0]        DEPTH_OCC  = (CNT_W + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DATA_WIDTH-1:0] word_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           push;
  logic           pop;

  // Credit counts the in-flight read so a full FIFO can never be overrun.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

  always_comb begin
    rom_cen     = 1'b0;
    rom_address = fetch_pc_q;
    if (!reset) begin
      if (redirect) begin
        rom_cen     = 1'b1;
        rom_address = redirect_pc;
      end else begin
        rom_cen = (occupancy < DEPTH_OCC);
      end
    end
  end

  assign push       = inflight_q && !redirect;
  assign pop        = (count_q != '0) && insn_ready && !redirect;
  assign insn_valid = (count_q != '0);
  assign insn       = word_mem_q[head_q];
  assign insn_pc    = pc_mem_q[head_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = rom_cen;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (rom_cen) begin
      inflight_pc_d = rom_address;
      fetch_pc_d    = rom_address + ADDR_WIDTH'(1);
    end

    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_ADDR;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clock) begin
    if (push) begin
      word_mem_q[tail_q] <= rom_q;
      pc_mem_q[tail_q]   <= inflight_pc_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_prefetch.sv
// ============================================================================
// tb_rom_prefetch : directed self-checking bench for rom_prefetch
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_rom_prefetch;

  logic        clock;
  logic        reset;
  logic [12:0] rom_address;
  logic        rom_cen;
  logic [15:0] rom_q;
  logic        redirect;
  logic [12:0] redirect_pc;
  logic        insn_valid;
  logic [15:0] insn;
  logic [12:0] insn_pc;
  logic        insn_ready;

  int n_checks = 0;
  int n_fail   = 0;

  rom_prefetch #(
    .ADDR_WIDTH(13),
    .DATA_WIDTH(16),
    .DEPTH     (4),
    .RESET_PC  (0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rom_address(rom_address),
    .rom_cen    (rom_cen),
    .rom_q      (rom_q),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .insn_valid (insn_valid),
    .insn       (insn),
    .insn_pc    (insn_pc),
    .insn_ready (insn_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] rom_word(input logic [12:0] a);
    return {3'b000, a} ^ 16'hA5A5;
  endfunction

  // Synchronous ROM: one-cycle read latency
  always @(posedge clock) begin
    if (rom_cen) rom_q <= rom_word(rom_address);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    chk("occupancy_le_depth", 32'(int'(dut.count_q) + int'(dut.inflight_q) <= 4), 32'd1);
  endtask

  task automatic pop_expect(input logic [12:0] pc);
    chk("pop_valid", 32'(insn_valid), 32'd1);
    chk("pop_pc", 32'(insn_pc), 32'(pc));
    chk("pop_insn", 32'(insn), 32'(rom_word(pc)));
    insn_ready = 1'b1;
    step();
  endtask

  initial begin
    reset       = 1'b1;
    insn_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid", 32'(insn_valid), 32'd0);
    chk("reset_cen", 32'(rom_cen), 32'd0);
    chk("reset_addr", 32'(rom_address), 32'd0);

    // First cycle after release issues RESET_PC
    reset = 1'b0;
    #1;
    chk("first_cen", 32'(rom_cen), 32'd1);
    chk("first_addr", 32'(rom_address), 32'd0);
    chk("first_valid", 32'(insn_valid), 32'd0);
    insn_ready = 1'b1;
    step();
    chk("cycle1_valid", 32'(insn_valid), 32'd0);
    step();
    for (int k = 0; k < 8; k++) pop_expect(13'(k));

    // Stall: FIFO fills, issue stops once count + inflight reaches 4
    insn_ready = 1'b0;
    step();
    chk("stall_c11_cen", 32'(rom_cen), 32'd1);
    chk("stall_c11_addr", 32'(rom_address), 32'd11);
    step();
    chk("stall_c12_cen", 32'(rom_cen), 32'd0);
    repeat (8) step();
    chk("stall_full_cen", 32'(rom_cen), 32'd0);
    chk("stall_full_count", 32'(dut.count_q), 32'd4);
    pop_expect(13'd8);
    chk("resume_cen", 32'(rom_cen), 32'd1);
    chk("resume_addr", 32'(rom_address), 32'd12);
    for (int k = 9; k < 16; k++) pop_expect(13'(k));

    // Redirect with 3 words queued and one read in flight
    insn_ready = 1'b0;
    step();
    chk("pre_redir_count", 32'(dut.count_q), 32'd3);
    chk("pre_redir_inflight", 32'(dut.inflight_q), 32'd1);
    chk("pre_redir_pc", 32'(insn_pc), 32'd16);
    redirect    = 1'b1;
    redirect_pc = 13'h0100;
    step();
    redirect = 1'b0;
    chk("redir_flush_valid", 32'(insn_valid), 32'd0);
    step();
    pop_expect(13'h0100);
    pop_expect(13'h0101);
    pop_expect(13'h0102);

    // Address wrap at top of code space
    redirect    = 1'b1;
    redirect_pc = 13'h1FFE;
    step();
    redirect = 1'b0;
    chk("wrap_flush_valid", 32'(insn_valid), 32'd0);
    step();
    pop_expect(13'h1FFE);
    pop_expect(13'h1FFF);
    pop_expect(13'h0000);
    pop_expect(13'h0001);

    // Back-to-back redirects: only the last target is delivered
    redirect    = 1'b1;
    redirect_pc = 13'h0010;
    step();
    redirect_pc = 13'h0020;
    step();
    redirect = 1'b0;
    chk("b2b_flush_valid", 32'(insn_valid), 32'd0);
    step();
    pop_expect(13'h0020);
    pop_expect(13'h0021);

    // Asynchronous reset mid-stream
    redirect    = 1'b1;
    redirect_pc = 13'h0030;
    step();
    redirect = 1'b0;
    step();
    pop_expect(13'h0030);
    pop_expect(13'h0031);
    pop_expect(13'h0032);
    chk("mid_head_valid", 32'(insn_valid), 32'd1);
    chk("mid_head_pc", 32'(insn_pc), 32'h33);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(insn_valid), 32'd0);
    chk("async_rst_cen", 32'(rom_cen), 32'd0);
    chk("async_rst_addr", 32'(rom_address), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("restart_cen", 32'(rom_cen), 32'd1);
    chk("restart_addr", 32'(rom_address), 32'd0);
    step();
    chk("restart_c1_valid", 32'(insn_valid), 32'd0);
    step();
    pop_expect(13'd0);
    pop_expect(13'd1);
    pop_expect(13'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
